// File: rtl/xor8_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared-XOR arbiter and
// the result consumer.
interface xor8_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id
    );
endinterface

// File: rtl/xor8_arbiter.sv
// Round-robin arbiter sharing one XOR8 gate unit between two requesters,
// with a one-entry result register tagged by requester id.

module xor8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_y
);
    for (genvar g = 0; g < 8; g++) begin : g_bit
        xor u_xor (o_y[g], i_a[g], i_b[g]);
    end
endmodule

// state    | meaning
// ST_EMPTY | result register holds nothing
// ST_FULL  | result register holds a result awaiting the consumer
module xor8_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    xor8_arbiter_if.slave io_bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0] r_state;
    logic       r_last;
    logic [7:0] r_res_data;
    logic       r_res_id;

    logic       w_full;
    logic       w_can_accept;
    logic       w_pick;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_accept;
    logic [7:0] w_op_a;
    logic [7:0] w_op_b;
    logic [7:0] w_xor;

    assign w_full       = (r_state == ST_FULL);
    assign w_can_accept = !i_rst && (!w_full || io_bus.res_ready);

    // With both requesting, the one not granted last wins.
    always_comb begin
        w_pick = io_bus.req1_valid;
        if (io_bus.req0_valid && io_bus.req1_valid) begin
            w_pick = ~r_last;
        end
    end

    assign w_gnt0   = w_can_accept && io_bus.req0_valid && !w_pick;
    assign w_gnt1   = w_can_accept && io_bus.req1_valid &&  w_pick;
    assign w_accept = w_gnt0 || w_gnt1;

    assign w_op_a = w_pick ? io_bus.req1_a : io_bus.req0_a;
    assign w_op_b = w_pick ? io_bus.req1_b : io_bus.req0_b;

    xor8 u_xor8 (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_y (w_xor)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_EMPTY;
            r_res_data <= 8'h00;
            r_res_id   <= 1'b0;
            r_last     <= ~RESET_PRIO;
        end else if (w_accept) begin
            r_state    <= ST_FULL;
            r_res_data <= w_xor;
            r_res_id   <= w_pick;
            r_last     <= w_pick;
        end else if (w_full && io_bus.res_ready) begin
            r_state    <= ST_EMPTY;
        end
    end

    assign io_bus.req0_ready = w_gnt0;
    assign io_bus.req1_ready = w_gnt1;
    assign io_bus.res_valid  = w_full;
    assign io_bus.res_data   = r_res_data;
    assign io_bus.res_id     = r_res_id;
endmodule
